// File: rtl/snow64_scalar_store_sequencer.sv
// Read-modify-write sequencer for a scalar store into one 256-bit LAR data line.
// Optional last-write bypass entry enabled by SNOW64_SCALAR_STORE_SEQUENCER_BYPASS_EN.
module snow64_scalar_store_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_req_valid,
  output logic         out_req_ready,
  input  logic [3:0]   in_req_lar_index,
  input  logic [63:0]  in_req_scalar,
  input  logic [1:0]   in_req_data_type,
  input  logic [1:0]   in_req_int_type_size,
  input  logic [4:0]   in_req_data_offset,
  output logic         out_lar_rd_req,
  output logic [3:0]   out_lar_rd_index,
  input  logic [255:0] in_lar_rd_data,
  output logic [255:0] out_inj_to_modify,
  output logic [63:0]  out_inj_to_shift,
  output logic [1:0]   out_inj_data_type,
  output logic [1:0]   out_inj_int_type_size,
  output logic [4:0]   out_inj_data_offset,
  input  logic [255:0] in_inj_data,
  output logic         out_lar_wr_en,
  output logic [3:0]   out_lar_wr_index,
  output logic [255:0] out_lar_wr_data,
  output logic         out_done,
  input  logic         in_bypass_flush
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_INJECT = 3'd3,
    ST_WRITE  = 3'd4
  } state_t;

  state_t         state_reg, state_next;
  logic [3:0]     index_reg;
  logic [63:0]    scalar_reg;
  logic [1:0]     data_type_reg;
  logic [1:0]     int_type_size_reg;
  logic [4:0]     data_offset_reg;
  logic [255:0]   line_reg;
  logic [255:0]   wr_data_reg;

  logic           accept;
  logic           bypass_hit;
  logic [255:0]   bypass_line;

  assign accept = in_req_valid & out_req_ready;

`ifdef SNOW64_SCALAR_STORE_SEQUENCER_BYPASS_EN
  logic           byp_valid_reg;
  logic [3:0]     byp_index_reg;
  logic [255:0]   byp_line_reg;

  // A flush in the acceptance cycle must force a miss, so it gates the hit test directly.
  assign bypass_hit  = byp_valid_reg & ~in_bypass_flush & (byp_index_reg == in_req_lar_index);
  assign bypass_line = byp_line_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_valid_reg <= 1'b0;
      byp_index_reg <= '0;
      byp_line_reg  <= '0;
    end else begin
      if (state_reg == ST_WRITE) begin
        byp_index_reg <= index_reg;
        byp_line_reg  <= wr_data_reg;
      end
      if (in_bypass_flush)
        byp_valid_reg <= 1'b0;
      else if (state_reg == ST_WRITE)
        byp_valid_reg <= 1'b1;
    end
  end
`else
  logic unused_bypass_flush;

  assign bypass_hit          = 1'b0;
  assign bypass_line         = '0;
  assign unused_bypass_flush = in_bypass_flush;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = bypass_hit ? ST_INJECT : ST_READ;
      ST_READ:   state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_INJECT;
      ST_INJECT: state_next = ST_WRITE;
      ST_WRITE:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    out_req_ready  = 1'b0;
    out_lar_rd_req = 1'b0;
    out_lar_wr_en  = 1'b0;
    out_done       = 1'b0;
    case (state_reg)
      ST_IDLE:  out_req_ready  = 1'b1;
      ST_READ:  out_lar_rd_req = 1'b1;
      ST_WRITE: begin
        out_lar_wr_en = 1'b1;
        out_done      = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are held for the whole operation; inputs are ignored while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_reg         <= '0;
      scalar_reg        <= '0;
      data_type_reg     <= '0;
      int_type_size_reg <= '0;
      data_offset_reg   <= '0;
    end else if (accept) begin
      index_reg         <= in_req_lar_index;
      scalar_reg        <= in_req_scalar;
      data_type_reg     <= in_req_data_type;
      int_type_size_reg <= in_req_int_type_size;
      data_offset_reg   <= in_req_data_offset;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_reg    <= '0;
      wr_data_reg <= '0;
    end else begin
      if (accept && bypass_hit)
        line_reg <= bypass_line;
      else if (state_reg == ST_LOAD)
        line_reg <= in_lar_rd_data;
      if (state_reg == ST_INJECT)
        wr_data_reg <= in_inj_data;
    end
  end

  assign out_lar_rd_index      = index_reg;
  assign out_inj_to_modify     = line_reg;
  assign out_inj_to_shift      = scalar_reg;
  assign out_inj_data_type     = data_type_reg;
  assign out_inj_int_type_size = int_type_size_reg;
  assign out_inj_data_offset   = data_offset_reg;
  assign out_lar_wr_index      = index_reg;
  assign out_lar_wr_data       = wr_data_reg;

endmodule

// File: doc/snow64_scalar_store_sequencer.md
# snow64_scalar_store_sequencer

Multi-cycle sequencer that performs a scalar store into one LAR's 256-bit data line as a read-modify-write. It accepts one store request at a time over a valid/ready handshake and reads the target line from the LAR file. It drives the scalar data injector's input fields and captures the injector's merged line. It then writes that line back to the LAR file. It sits between the scalar-store issue logic upstream and the LAR file and scalar data injector downstream.

## Interface
Parameters: none. Widths come from the shared Snow64 defines: LAR data 256, scalar 64, data type 2, int type size 2, data offset 5, LAR index 4.

Clocking: one clock. Reset is asynchronous and active-high.

- clk  in  1  sole clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_req_valid  in  1  store request present
- out_req_ready  out  1  sequencer can accept a request
- in_req_lar_index  in  4  target LAR
- in_req_scalar  in  64  scalar to store
- in_req_data_type  in  2  passed through to the injector
- in_req_int_type_size  in  2  passed through to the injector
- in_req_data_offset  in  5  byte offset within the line
- out_lar_rd_req  out  1  LAR file read strobe
- out_lar_rd_index  out  4  read index
- in_lar_rd_data  in  256  read data, valid the cycle after out_lar_rd_req
- out_inj_to_modify  out  256  injector line input
- out_inj_to_shift  out  64  injector scalar input
- out_inj_data_type  out  2  injector input
- out_inj_int_type_size  out  2  injector input
- out_inj_data_offset  out  5  injector input
- in_inj_data  in  256  merged line from the injector (combinational)
- out_lar_wr_en  out  1  LAR file write strobe
- out_lar_wr_index  out  4  write index
- out_lar_wr_data  out  256  write data
- out_done  out  1  one-cycle pulse, coincident with out_lar_wr_en
- in_bypass_flush  in  1  invalidates the bypass entry (see Configuration)

## Operation
- States: IDLE, READ, LOAD, INJECT, WRITE.
- Reset values:
  - state = IDLE.
  - All registers = 0; all outputs = 0 except out_req_ready = 1.
  - Bypass entry invalid.
- IDLE:
  - out_req_ready = 1.
  - On in_req_valid & out_req_ready, capture all request fields, then go to READ (or INJECT on a bypass hit).
- READ:
  - out_lar_rd_req = 1 and out_lar_rd_index = captured index, for exactly one cycle.
  - Next state: LOAD.
- LOAD:
  - Capture in_lar_rd_data into the line register.
  - Next state: INJECT.
- INJECT:
  - out_inj_* show the captured line, scalar, type, size and offset.
  - Capture in_inj_data into the write register.
  - Next state: WRITE.
- WRITE:
  - out_lar_wr_en = 1 and out_done = 1 for one cycle.
  - out_lar_wr_index = captured index; out_lar_wr_data = write register.
  - Next state: IDLE.
- out_req_ready = 0 in every state except IDLE. No request is queued, and in_req_* are ignored while busy.
- out_inj_* are driven from registers in every state. They are only meaningful in INJECT.
- data_type, int_type_size and offset are not interpreted or checked. Alignment is the injector's concern.
- rst asserted mid-operation:
  - Return to IDLE immediately; no write is issued.
  - A pending out_lar_wr_en is dropped; the bypass entry is invalidated.

## Timing
- Request accepted at edge t (end of the IDLE cycle):
  - READ in cycle t+1.
  - LOAD in cycle t+2.
  - INJECT in cycle t+3.
  - WRITE (out_lar_wr_en, out_done) in cycle t+4.
  - out_req_ready returns to 1 in cycle t+5.
- Throughput without a bypass hit: one store per 5 cycles.
- Bypass hit: INJECT in t+1, WRITE in t+2, ready again in t+3.

## Configuration
- Macro: SNOW64_SCALAR_STORE_SEQUENCER_BYPASS_EN.
- Defined:
  - A bypass entry holds {valid, index, line}. It is loaded with the write index and data in every WRITE cycle.
  - An accepted request with entry valid and matching index loads the line register from the entry and goes straight to INJECT, skipping READ and LOAD. No out_lar_rd_req is issued.
  - in_bypass_flush = 1 clears valid. Flush in the same cycle as WRITE wins, so the entry ends invalid.
  - Flush in the same cycle as an acceptance is sampled before the hit test, so the request misses.
- Undefined:
  - No bypass storage; every request takes the full 5-cycle path.
  - in_bypass_flush is ignored.

## Test plan
- Reset:
  - Assert rst mid-LOAD -> state returns to IDLE.
  - out_req_ready = 1; no out_lar_wr_en follows; all other outputs are 0.
- Basic store:
  - Request index 3, scalar 0x00000000_000000AB, offset 5, with the LAR model returning line L and the injector model returning L with byte 5 replaced by 0xAB.
  - out_lar_rd_req at t+1 with index 3.
  - out_inj_to_modify = L at t+3.
  - out_lar_wr_en, out_done and index 3 at t+4, with wr_data = the injector result.
- Busy:
  - Hold in_req_valid high with different fields during t+1..t+4 -> out_req_ready = 0 throughout.
  - The second request is accepted only at t+5.
- Bypass hit (macro on):
  - Back-to-back stores to index 7 -> the second has no out_lar_rd_req.
  - The second's out_inj_to_modify equals the first's written line.
  - The second's WRITE occurs 2 cycles after its acceptance.
- Bypass flush/miss (macro on):
  - Pulse in_bypass_flush, or target index 8 after a write to 7 -> full 5-cycle path with out_lar_rd_req issued.
  - Flush asserted during WRITE leaves the entry invalid.
